// File: rtl/accum_drain_engine.sv
`default_nettype none
// ============================================================================
// Module  : accum_drain_engine
// Purpose : Streams a contiguous accumulator row range out on a credit-limited
//           ready/valid stream, optionally zeroing each row after reading it.
// Revision: 1.0 - initial release
// ============================================================================
module accum_drain_engine #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int ZONE_WIDTH = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           cfg_base,
    input  logic [ADDR_WIDTH:0]             cfg_len,
    input  logic [ZONE_WIDTH-1:0]           cfg_zone,
    input  logic [NUM_BANKS-1:0]            cfg_mask,
    input  logic                            cfg_clr,
    output logic                            busy,
    output logic                            done,
    output logic                            err_unexp,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [NUM_BANKS-1:0]            rd_mask,
    output logic [ZONE_WIDTH-1:0]           rd_zone_id,
    input  logic                            rvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [NUM_BANKS-1:0]            wr_mask,
    output logic [ZONE_WIDTH-1:0]           wr_zone_id,
    output logic                            accum_en,
    output logic                            wvalid,
    input  logic                            wready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] m_data,
    output logic                            m_last
);

    localparam int c_ROW_W = NUM_BANKS * DATA_WIDTH;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_LEN_W = ADDR_WIDTH + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_CLR     = 3'd3,
        S_FLUSH   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [c_LEN_W-1:0]      r_len;
    logic [c_LEN_W-1:0]      r_issued;
    logic [c_LEN_W-1:0]      r_dlv;
    logic [ZONE_WIDTH-1:0]   r_zone;
    logic [NUM_BANKS-1:0]    r_mask;
    logic                    r_clr;
    logic [ADDR_WIDTH-1:0]   r_rd_addr;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic                    r_rd_valid;
    logic                    r_wr_valid;
    logic                    r_wvalid;
    logic [c_CNT_W-1:0]      r_outst;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [c_PTR_W-1:0]      r_wptr;
    logic [c_PTR_W-1:0]      r_rptr;
    logic [c_ROW_W-1:0]      r_mem [FIFO_DEPTH];

    logic                    w_start_acc;
    logic                    w_rd_fire;
    logic                    w_rsp;
    logic                    w_unexp;
    logic                    w_pop;
    logic [c_CNT_W-1:0]      w_outst_nxt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic                    w_credit_ok;
    logic                    w_last_issue;
    logic                    w_wr_pend_nxt;
    logic                    w_w_pend_nxt;
    logic                    w_rd_valid_nxt;

    assign w_start_acc   = start && !r_busy;
    assign w_rd_fire     = r_rd_valid && rd_ready;
    assign w_rsp         = rvalid && (r_outst != '0);
    assign w_unexp       = rvalid && (r_outst == '0);
    assign w_pop         = (r_cnt != '0) && m_ready;
    assign w_outst_nxt   = r_outst + c_CNT_W'(w_rd_fire) - c_CNT_W'(w_rsp);
    assign w_cnt_nxt     = r_cnt + c_CNT_W'(w_rsp) - c_CNT_W'(w_pop);
    // Credits are judged on next-cycle occupancy so a read never overruns the FIFO
    assign w_credit_ok   = ({1'b0, w_outst_nxt} + {1'b0, w_cnt_nxt}) < c_DEPTH;
    assign w_last_issue  = (r_issued + c_LEN_W'(1)) == r_len;
    assign w_wr_pend_nxt = r_wr_valid && !wr_ready;
    assign w_w_pend_nxt  = r_wvalid && !wready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = (cfg_len == '0) ? S_FLUSH : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (w_rd_fire) begin
                    if (r_clr) begin
                        w_state_nxt = S_RD_WAIT;
                    end else if (w_last_issue) begin
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_RD_WAIT: begin
                if (w_rsp) begin
                    w_state_nxt = S_CLR;
                end
            end
            S_CLR: begin
                if (!w_wr_pend_nxt && !w_w_pend_nxt) begin
                    w_state_nxt = (r_issued == r_len) ? S_FLUSH : S_RD_REQ;
                end
            end
            S_FLUSH: begin
                if ((r_cnt == '0) && (r_outst == '0)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A pending request is held until accepted; a fresh one needs a free credit
    assign w_rd_valid_nxt = (w_state_nxt == S_RD_REQ) &&
                            ((r_rd_valid && !rd_ready) || w_credit_ok);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_len      <= '0;
            r_issued   <= '0;
            r_dlv      <= '0;
            r_zone     <= '0;
            r_mask     <= '0;
            r_clr      <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_addr  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wvalid   <= 1'b0;
            r_outst    <= '0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (r_state == S_FLUSH) && (w_state_nxt == S_IDLE);
            r_rd_valid <= w_rd_valid_nxt;
            r_outst    <= w_outst_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_rsp) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end

            if (w_start_acc) begin
                r_len     <= cfg_len;
                r_zone    <= cfg_zone;
                r_mask    <= cfg_mask;
                r_clr     <= cfg_clr;
                r_rd_addr <= cfg_base;
                r_issued  <= '0;
                r_dlv     <= '0;
            end else begin
                if (w_rd_fire) begin
                    r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                    r_wr_addr <= r_rd_addr;
                    r_issued  <= r_issued + c_LEN_W'(1);
                end
                if (w_pop) begin
                    r_dlv <= r_dlv + c_LEN_W'(1);
                end
            end

            if (w_unexp) begin
                r_err <= 1'b1;
            end else if (w_start_acc) begin
                r_err <= 1'b0;
            end

            if ((r_state == S_RD_WAIT) && (w_state_nxt == S_CLR)) begin
                r_wr_valid <= 1'b1;
                r_wvalid   <= 1'b1;
            end else begin
                r_wr_valid <= w_wr_pend_nxt;
                r_wvalid   <= w_w_pend_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp) begin
            r_mem[r_wptr] <= rdata;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err_unexp  = r_err;
    assign rd_valid   = r_rd_valid;
    assign rd_addr    = r_rd_addr;
    assign rd_mask    = r_mask;
    assign rd_zone_id = r_zone;
    assign wr_valid   = r_wr_valid;
    assign wr_addr    = r_wr_addr;
    assign wr_mask    = r_mask;
    assign wr_zone_id = r_zone;
    assign accum_en   = 1'b0;
    assign wvalid     = r_wvalid;
    assign wdata      = '0;
    assign m_valid    = (r_cnt != '0);
    assign m_data     = r_mem[r_rptr];
    assign m_last     = m_valid && ((r_dlv + c_LEN_W'(1)) == r_len);

endmodule
`default_nettype wire

// File: doc/accum_drain_engine.md
# accum_drain_engine

Drain engine that sits directly downstream of the accumulator subsystem, attached to one routed master port. On a start command it reads a contiguous range of accumulator rows from one zone and streams each row out on a ready/valid stream with credit-based flow control. Optionally it clears each row to zero after reading it, so the zone is ready for the next tile. Typical use is result readout between accumulation passes.

## Interface
- NUM_BANKS, 4, banks per row; also the width of the row mask
- ADDR_WIDTH, 9, row address width
- DATA_WIDTH, 64, bits per bank
- ZONE_WIDTH, 2, zone id width
- FIFO_DEPTH, 4, output buffer depth in rows (power of 2, ≥2); also the outstanding-read credit limit

Ports:
- clk  in  1  clock; everything is sampled on rising edge
- rstn  in  1  synchronous, active-low reset
- start  in  1  one-cycle command strobe; ignored while busy=1
- cfg_base  in  ADDR_WIDTH  first row address
- cfg_len  in  ADDR_WIDTH+1  number of rows; 0 is legal
- cfg_zone  in  ZONE_WIDTH  target zone
- cfg_mask  in  NUM_BANKS  bank mask, used on every read and clear
- cfg_clr  in  1  1 = zero each row after it is read
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err_unexp  out  1  sticky; set when rvalid arrives with no read outstanding; cleared by reset or by an accepted start
- rd_valid / rd_ready  out / in  1  read command handshake
- rd_addr  out  ADDR_WIDTH  read row address
- rd_mask  out  NUM_BANKS  read bank mask
- rd_zone_id  out  ZONE_WIDTH  read zone
- rvalid  in  1  read data strobe; no backpressure is possible on this path
- rdata  in  NUM_BANKS*DATA_WIDTH  read data; bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH]
- wr_valid / wr_ready  out / in  1  clear-write command handshake
- wr_addr, wr_mask, wr_zone_id  out  ADDR_WIDTH, NUM_BANKS, ZONE_WIDTH  clear-write fields
- accum_en  out  1  constant 0
- wvalid / wready  out / in  1  clear-write data handshake
- wdata  out  NUM_BANKS*DATA_WIDTH  constant 0
- m_valid / m_ready  out / in  1  output stream handshake
- m_data  out  NUM_BANKS*DATA_WIDTH  row data
- m_last  out  1  marks the final row of the command

## Operation
- Command latch: an accepted start (start && !busy) latches all cfg_* inputs and clears err_unexp.
- FSM states: IDLE, RD_REQ, RD_WAIT, CLR, FLUSH.
- IDLE
  - cfg_len=0: go to FLUSH with nothing issued.
  - otherwise: go to RD_REQ.
- RD_REQ
  - rd_valid is asserted only when outstanding + fifo_count < FIFO_DEPTH.
  - On each rd handshake: the issue counter increments and the address increments modulo 2^ADDR_WIDTH (0x1FF wraps to 0x000).
  - cfg_clr=0: reads are pipelined. After the last read is issued, go to FLUSH.
  - cfg_clr=1: after each read is issued, go to RD_WAIT.
- RD_WAIT: wait for that row's rvalid, then go to CLR.
- CLR
  - wr_valid and wvalid assert together, with wr_addr equal to the address just read.
  - Each signal drops independently after its own handshake.
  - When both handshakes have completed: go to RD_REQ, or to FLUSH if that was the last row.
- FLUSH: wait until the FIFO is empty and the outstanding count is 0, then assert done for one cycle and return to IDLE.
- Outstanding counter: +1 on rd handshake, −1 on rvalid, both in the same cycle give no change.
- Unexpected rvalid: rvalid while outstanding=0 sets err_unexp and the data is discarded.
- FIFO: write on rvalid (never full, guaranteed by the credit rule); read on m_valid && m_ready; simultaneous write and read is legal.
- m_last: set on the beat whose delivered-row count equals cfg_len.
- Row order: m_data rows are delivered in address order.

## Timing
- Reset: the following are 0 from the first clk edge with rstn=0:
  - busy, done, err_unexp
  - rd_valid, wr_valid, wvalid
  - m_valid, m_last
  - all address, zone and mask outputs
- Reset also empties the FIFO and zeros all counters. This applies in every state, including mid-command.
- Start accepted at edge T: busy=1 from T+1, rd_valid may assert from T+1.
- rd_* and wr_* fields are registered and stay stable while valid is high and unacknowledged.
- Data path: rvalid at edge R gives m_valid=1 from R+1, when the FIFO was empty.
- cfg_len=0: done pulses at T+2 with no bus activity.
- done: asserted the cycle after the final m handshake (and, if cfg_clr=1, after the final clear handshakes have also completed). busy falls together with done.

## Test plan
- Pipelined read
  - Stimulus: zone 1, base 0x020, len 4, cfg_clr=0, m_ready=1, read latency 2, rdata bank b = addr+b.
  - Required: 4 beats for addresses 0x020–0x023 in order, rd_zone_id=1, m_last on beat 4 only, one done pulse.
- Backpressure and credits
  - Stimulus: FIFO_DEPTH=4, len 10, m_ready=0 for 30 cycles, then 1.
  - Required: at most 4 rd handshakes while stalled, no lost or duplicated row, all 10 rows delivered in order.
- Clear mode
  - Stimulus: len 3, cfg_clr=1, mask 4'b0101, wr_ready delayed 3 cycles, wready delayed 1 cycle.
  - Required: each row read, then a write to the same address with wdata=0, accum_en=0, mask 4'b0101; never two reads outstanding.
- Wrap-around
  - Stimulus: base 0x1FE, len 4.
  - Required: rd_addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Zero length and start while busy
  - Stimulus: len 0; then a second start pulsed while busy.
  - Required: done at T+2 with no rd_valid; the second start is ignored.
- Reset mid-operation and stray data
  - Stimulus: rstn=0 mid-command.
  - Required: all outputs 0 on the next edge and the FIFO empty.
  - Stimulus: after reset, drive rvalid with nothing outstanding.
  - Required: err_unexp=1 and m_valid stays 0.
